// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment glyph table, segment bit positions and
//                nibble-to-glyph lookup function (active-high, {g,f,e,d,c,b,a}).
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // Bit positions within a seg7_t word
    localparam int unsigned c_seg_a = 0;
    localparam int unsigned c_seg_b = 1;
    localparam int unsigned c_seg_c = 2;
    localparam int unsigned c_seg_d = 3;
    localparam int unsigned c_seg_e = 4;
    localparam int unsigned c_seg_f = 5;
    localparam int unsigned c_seg_g = 6;

    // Entry 15 is leftmost: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0
    localparam logic [15:0][6:0] c_glyph = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic seg7_t seg7_glyph(input logic [3:0] nibble);
        return c_glyph[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7_glyph.sv
`default_nettype none
// ============================================================================
//  Module      : hex7_glyph
//  Description : Combinational hex nibble to 7-segment glyph (active-high).
//  Revision    : 1.0  initial release
// ============================================================================
module hex7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = seg7_glyph(nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed N-digit 7-segment driver with prescaler,
//                dead time, leading-zero blanking and frame-coherent capture.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NDIGITS     = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD        = 2,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   blank_lz,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_tick
);

    localparam int c_pre_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
    localparam logic [c_pre_w-1:0] c_dead     = c_pre_w'(DEAD);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NDIGITS - 1);

    // "Off" patterns double as XOR masks that apply the pin polarity
    localparam logic [6:0]         c_seg_off = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic               c_dp_off  = (SEG_ACT_LOW != 0);
    localparam logic [NDIGITS-1:0] c_an_off  = (AN_ACT_LOW != 0) ? {NDIGITS{1'b1}}
                                                                 : {NDIGITS{1'b0}};

    logic [c_pre_w-1:0]   r_pre;
    logic [c_idx_w-1:0]   r_idx;
    logic [4*NDIGITS-1:0] r_shadow_val;
    logic [NDIGITS-1:0]   r_shadow_dp;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [NDIGITS-1:0]   r_an;
    logic                 r_frame_tick;

    logic                 w_snap;
    logic                 w_pre_wrap;
    logic                 w_dead;
    logic                 w_lit;
    logic [3:0]           w_nibble;
    logic                 w_dp_sel;
    logic                 w_cur_blank;
    logic [NDIGITS-1:0]   w_onehot;
    logic [6:0]           w_glyph;

    assign w_snap     = (r_pre == '0) && (r_idx == '0);
    assign w_pre_wrap = (r_pre == c_pre_last);
    assign w_dead     = (r_pre < c_dead);

    // Digit select and blanking: walk from the MSD down, tracking whether
    // every shadow nibble seen so far is zero.
    always_comb begin
        logic v_zero_run;
        v_zero_run  = 1'b1;
        w_nibble    = 4'h0;
        w_dp_sel    = 1'b0;
        w_cur_blank = 1'b0;
        w_onehot    = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            v_zero_run = v_zero_run && (r_shadow_val[4*i +: 4] == 4'h0);
            if (r_idx == c_idx_w'(i)) begin
                w_nibble    = r_shadow_val[4*i +: 4];
                w_dp_sel    = r_shadow_dp[i];
                w_onehot[i] = 1'b1;
                w_cur_blank = (i > 0) && blank_lz && v_zero_run;
            end
        end
    end

    hex7_glyph u_glyph (
        .nibble (w_nibble),
        .glyph  (w_glyph)
    );

    assign w_lit = enable && !w_dead && !w_cur_blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_seg        <= c_seg_off;
            r_dp         <= c_dp_off;
            r_an         <= c_an_off;
            r_frame_tick <= 1'b0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
            if (w_pre_wrap) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            if (w_snap) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            r_frame_tick <= w_snap;
            r_seg        <= (w_lit ? w_glyph  : 7'h00) ^ c_seg_off;
            r_dp         <= (w_lit ? w_dp_sel : 1'b0)  ^ c_dp_off;
            r_an         <= (w_lit ? w_onehot : '0)    ^ c_an_off;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench: 4-digit active-low instance
//                plus a 1-digit active-high instance sharing clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    logic [3:0]  b_value;
    logic [0:0]  b_dp_in;
    logic [6:0]  b_seg;
    logic        b_dp;
    logic [0:0]  b_an;
    logic        b_ft;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .NDIGITS(4), .SCAN_DIV(4), .DEAD(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
        .value(value), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(
        .NDIGITS(1), .SCAN_DIV(4), .DEAD(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(0)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
        .value(b_value), .dp_in(b_dp_in),
        .seg(b_seg), .dp(b_dp), .an(b_an), .frame_tick(b_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input logic eft);
        chk({tag, ".an"},  32'(an),         32'(ean));
        chk({tag, ".seg"}, 32'(seg),        32'(eseg));
        chk({tag, ".dp"},  32'(dp),         32'(edp));
        chk({tag, ".ft"},  32'(frame_tick), 32'(eft));
    endtask

    task automatic chk_b(input string tag, input logic ean, input logic [6:0] eseg,
                         input logic edp, input logic eft);
        chk({tag, ".b_an"},  32'(b_an),  32'(ean));
        chk({tag, ".b_seg"}, 32'(b_seg), 32'(eseg));
        chk({tag, ".b_dp"},  32'(b_dp),  32'(edp));
        chk({tag, ".b_ft"},  32'(b_ft),  32'(eft));
    endtask

    // One digit slot: three lit cycles, then the dead cycle opening the next slot.
    task automatic slot(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                        input logic edp, input logic eft, input logic b_lit);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_a(tag, ean, eseg, edp, 1'b0);
            chk_b(tag, b_lit, b_lit ? 7'h7F : 7'h00, 1'b0, 1'b0);
        end
        step();
        chk_a({tag, ".dead"}, 4'hF, 7'h7F, 1'b1, eft);
        chk_b({tag, ".dead"}, 1'b0, 7'h00, 1'b0, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        blank_lz = 1'b0;
        value    = 16'h12AF;
        dp_in    = 4'b0000;
        b_value  = 4'h8;
        b_dp_in  = 1'b0;

        repeat (3) step();
        chk_a("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        chk_b("reset", 1'b0, 7'h00, 1'b0, 1'b0);
        reset = 1'b0;

        step();
        chk_a("first_snap", 4'hF, 7'h7F, 1'b1, 1'b1);
        chk_b("first_snap", 1'b0, 7'h00, 1'b0, 1'b1);
        repeat (2) begin
            step();
            chk_a("pre_rst_lit", 4'hE, 7'h0E, 1'b1, 1'b0);
            chk_b("pre_rst_lit", 1'b1, 7'h7F, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a lit slot
        #3 reset = 1'b1;
        #1;
        chk_a("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
        chk_b("async_rst", 1'b0, 7'h00, 1'b0, 1'b0);
        step();
        chk_a("rst_held", 4'hF, 7'h7F, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        chk_a("snap_after_rst", 4'hF, 7'h7F, 1'b1, 1'b1);
        chk_b("snap_after_rst", 1'b0, 7'h00, 1'b0, 1'b1);

        // Plain scan of 12AF
        slot("scan0", 4'hE, 7'h0E, 1'b1, 1'b0, 1'b1);
        slot("scan1", 4'hD, 7'h08, 1'b1, 1'b0, 1'b1);
        slot("scan2", 4'hB, 7'h24, 1'b1, 1'b0, 1'b1);
        value = 16'h0070;
        slot("scan3", 4'h7, 7'h79, 1'b1, 1'b1, 1'b1);
        blank_lz = 1'b1;

        // Leading-zero blanking, 0070
        slot("lz70_0", 4'hE, 7'h40, 1'b1, 1'b0, 1'b1);
        slot("lz70_1", 4'hD, 7'h78, 1'b1, 1'b0, 1'b1);
        slot("lz70_2", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
        value = 16'h0000;
        slot("lz70_3", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);

        // Leading-zero blanking, 0000
        slot("lz0_0", 4'hE, 7'h40, 1'b1, 1'b0, 1'b1);
        slot("lz0_1", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
        slot("lz0_2", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1);
        value = 16'h1111;
        slot("lz0_3", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);
        blank_lz = 1'b0;

        // Tearing: mid-frame change stays invisible until next snapshot
        slot("tear0", 4'hE, 7'h79, 1'b1, 1'b0, 1'b1);
        slot("tear1", 4'hD, 7'h79, 1'b1, 1'b0, 1'b1);
        value = 16'h2222;
        dp_in = 4'b0100;
        slot("tear2", 4'hB, 7'h79, 1'b1, 1'b0, 1'b1);
        slot("tear3", 4'h7, 7'h79, 1'b1, 1'b1, 1'b1);

        // New frame: 2222 with dp on digit 2
        slot("new0", 4'hE, 7'h24, 1'b1, 1'b0, 1'b1);
        slot("new1", 4'hD, 7'h24, 1'b1, 1'b0, 1'b1);
        slot("new2", 4'hB, 7'h24, 1'b0, 1'b0, 1'b1);
        slot("new3", 4'h7, 7'h24, 1'b1, 1'b1, 1'b1);
        enable = 1'b0;

        // Disabled: everything dark, frame_tick keeps pulsing
        slot("off0", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        slot("off1", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        slot("off2", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        slot("off3", 4'hF, 7'h7F, 1'b1, 1'b1, 1'b0);
        enable = 1'b1;

        slot("reen0", 4'hE, 7'h24, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display bank. It generalises the single-digit hex decoder to a parametrised digit count, configurable polarity, and leading-zero blanking. It adds a scan prescaler, anti-ghosting dead time and frame-coherent value capture. It sits between the MIPS debug/status registers and the board display pins.

## Interface
- NDIGITS, 4: number of digits, legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot, minimum 2.
- DEAD, 2: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ DEAD < SCAN_DIV.
- SEG_ACT_LOW, 1: 1 means segment and dp pins are active-low.
- AN_ACT_LOW, 1: 1 means anode pins are active-low.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  0 forces all outputs inactive; counters keep running.
- blank_lz  in  1  leading-zero blanking enable.
- value  in  4*NDIGITS  hex value; nibble i drives digit i, digit 0 is the LSD.
- dp_in  in  NDIGITS  decimal point request per digit.
- seg  out  7  segment pins, bit order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point pin.
- an  out  NDIGITS  digit anode pins; one-hot when active.
- frame_tick  out  1  one-cycle pulse marking a new frame snapshot.

## Operation
- **Prescaler:** `pre` counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and digit index `idx` advances by one; `idx` wraps from NDIGITS-1 to 0.
- **Snapshot:** on every cycle with `pre==0 && idx==0`, including the first cycle after reset release, `value` and `dp_in` load into shadow registers. The display uses only the shadow copies, so a frame never mixes two values.
- **Glyphs, active-high, gfedcba:**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Leading-zero blanking:** digit i (i>0) is blanked when blank_lz=1 and shadow nibbles NDIGITS-1..i are all zero. Digit 0 is never blanked.
- **Blanked digit:** its anode stays inactive, as does dp.
- **Dead time:** while `pre < DEAD`, all anodes are inactive and seg/dp are inactive.
- **Active slot:** `an` is one-hot at `idx`, `seg` carries the glyph of shadow nibble `idx`, and `dp` carries shadow dp bit `idx`.
- **Disabled:** enable=0 drives all outputs inactive, except frame_tick, which still pulses.
- **Polarity:** each polarity parameter inverts its group of pins. "Inactive" means all-ones when active-low and all-zeros when active-high.

## Timing
- seg, dp, an and frame_tick are all registered. Each output reflects the `pre`/`idx`/shadow state of the previous cycle, giving one cycle of latency.
- frame_tick is high for exactly one cycle, the cycle after a snapshot.
- Frame period is NDIGITS*SCAN_DIV cycles.
- Digit slot k has anodes off during its first DEAD output cycles, then lit for SCAN_DIV-DEAD cycles.
- On reset, asserted asynchronously at any time including mid-slot:
  - pre=0, idx=0, shadows=0;
  - an, seg and dp inactive;
  - frame_tick=0.
- After reset deasserts, the first snapshot happens on the first clock edge. The first lit digit appears DEAD+1 cycles later.
- Changes to value/dp_in/blank_lz between snapshots:
  - value and dp_in changes are invisible until the next snapshot;
  - blank_lz is sampled live, with one cycle of latency.
- When NDIGITS=1, idx stays 0 and every slot is a new frame.
- Prescaler width is clog2(SCAN_DIV) and idx width is clog2(NDIGITS), with a minimum of 1. Both wrap explicitly, never by overflow.

## Structure
- Package `seg7_pkg` holds:
  - the 16-entry glyph constant array;
  - the segment bit-order constants;
  - a `seg7_glyph(nibble)` function.
- One combinational sub-module, `hex7_glyph`, does nibble-to-glyph lookup (active-high output) and is shared with other display users. Polarity inversion lives in `seg7_scan_driver`.
- Everything else is flat: prescaler, idx counter, shadow registers, blanking mask and output registers.

## Test plan
Use NDIGITS=4, SCAN_DIV=4, DEAD=1, both polarities active-low, unless noted.
- **Reset mid-slot:** assert reset asynchronously mid-slot. Outputs immediately go to an=1111, seg=7F, dp=1, frame_tick=0. After release, frame_tick pulses on cycle 2.
- **Plain scan:** value=12AF, blank_lz=0. Required outputs per slot:
  - slot 0: an=1110, seg=0E;
  - slot 1: an=1101, seg=08;
  - slot 2: an=1011, seg=24;
  - slot 3: an=0111, seg=79;
  - each slot starts with one an=1111 cycle.
- **Leading-zero blanking:** blank_lz=1.
  - value=0070: digits 3 and 2 stay an-off; digit 1 shows seg=78; digit 0 shows seg=40.
  - value=0000: only digit 0 lights, with seg=40.
- **Tearing:** change value from 1111 to 2222 during slot 2. Slot 3 still shows 1. The next frame, starting after frame_tick, shows 2 on every digit.
- **dp and enable:** dp_in=0100 gives dp=0 only in slot 2. With enable=0, an=1111 and seg=7F throughout, while frame_tick keeps pulsing every 16 cycles.
- **Polarity and width sweep:** NDIGITS=1, SEG_ACT_LOW=0, AN_ACT_LOW=0, value=8. Required: an=1, seg=7F for 3 of every 4 cycles; an=0, seg=00 during dead time.
